// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: line geometry, default reset PC, fetch FSM state encodings and
// a helper that aligns a byte address down to the start of its line.
package inst_fetch_queue_pkg;

    localparam int unsigned FETCH_WIDTH      = 4;                       // instructions per line
    localparam int unsigned INST_BYTES       = 4;                       // rv32 instruction size
    localparam int unsigned LINE_BYTES       = FETCH_WIDTH * INST_BYTES;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // ST_REQ   : request line at fetch_pc, o_pc_valid held until the return strobe
    // ST_HOLD  : queue has no free slot, no request outstanding
    // ST_DRAIN : redirect arrived while a request was outstanding; wait out and
    //            drop the stale return before fetching from the new PC
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Clear the byte-offset-within-line bits of an address.
    function automatic logic [31:0] line_align(input logic [31:0] pc,
                                               input int unsigned line_bytes);
        return pc & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Generic synchronous FIFO with a synchronous clear and an occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must not push when full unless popping the same cycle.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_clear             drop all entries (has priority over push/pop)
//   i_push_vld/_dat     write an entry
//   i_pop_rdy           consume the head entry (ignored when empty)
//   o_head_dat          head entry (undefined contents when empty)
//   o_empty, o_count    occupancy status
module inst_fetch_queue_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4    // power of 2, >= 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop_rdy,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign pop_ok  = i_pop_rdy && !o_empty;

    assign o_head_dat = mem[rd_ptr_q];
    assign o_count    = count_q;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_push_vld) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(i_push_vld) - CNT_W'(pop_ok);
        end
    end

    // Storage is not reset; occupancy tracking alone decides what is valid.
    // When full, a simultaneous pop frees the slot being written: the head is
    // read combinationally before the edge, so the overwrite is safe.
    always_ff @(posedge i_clk) begin
        if (i_push_vld && !i_clear) begin
            mem[wr_ptr_q] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear) begin
            assert (!(i_push_vld && full && !pop_ok));
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, requests lines from instMEM and queues them for decode.
// Latency: a returned line is presented to decode the cycle after i_inst_ready (no bypass).
// Backpressure: line requests stop (HOLD) when every queue slot is filled or reserved.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_redirect, i_redirect_pc      flush the queue and restart fetch at a new PC
//   o_pc_valid, o_pc               line request to instMEM (o_pc line aligned)
//   i_inst_ready, i_rinst          one-cycle line return strobe and line data (slot0 in [31:0])
//   o_inst_valid, o_inst           head line to decode
//   o_inst_pc, o_inst_mask         line-aligned PC of the head line, valid-slot mask
//   i_dec_ready                    decode consumes the head line this cycle
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned FETCH_W  = FETCH_WIDTH,      // power of 2, >= 2
    parameter int unsigned DEPTH    = 4,                // power of 2, >= 2
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_pc_valid,
    output logic [31:0]           o_pc,
    input  logic                  i_inst_ready,
    input  logic [FETCH_W*32-1:0] i_rinst,
    output logic                  o_inst_valid,
    output logic [FETCH_W*32-1:0] o_inst,
    output logic [31:0]           o_inst_pc,
    output logic [FETCH_W-1:0]    o_inst_mask,
    input  logic                  i_dec_ready
);

    localparam int unsigned LINE_B = FETCH_W * INST_BYTES;
    localparam int unsigned OFF_W  = $clog2(LINE_B);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [FETCH_W*32-1:0] line;
        logic [31:0]           pc;
        logic [FETCH_W-1:0]    mask;
    } q_entry_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drain_pc_q, drain_pc_d;   // PC still shown to instMEM while draining
    logic         first_q, first_d;         // next kept line is the first after reset/redirect
    logic         rst_dly_q;                // first cycle out of reset

    logic         line_ret;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    q_entry_t     push_entry;
    q_entry_t     head_entry;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
            first_q    <= 1'b1;
            rst_dly_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drain_pc_q <= drain_pc_d;
            first_q    <= first_d;
            rst_dly_q  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // A return strobe only counts while a request is outstanding. One in the
    // first cycle out of reset cannot belong to a request made since reset.
    assign line_ret = i_inst_ready && (state_q != ST_HOLD) && !rst_dly_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drain_pc_d = drain_pc_q;
        first_d    = first_q;
        fifo_push  = 1'b0;

        if (i_redirect) begin
            // The queue is cleared this edge, so credit is always available
            // afterwards; only an unanswered request forces a drain.
            fetch_pc_d = i_redirect_pc;
            first_d    = 1'b1;
            unique case (state_q)
                ST_REQ: begin
                    if (line_ret) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_DRAIN;
                        drain_pc_d = fetch_pc_q;
                    end
                end
                ST_DRAIN: state_d = line_ret ? ST_REQ : ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (line_ret) begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = line_align(fetch_pc_q, LINE_B) + 32'(LINE_B);
                        first_d    = 1'b0;
                        // The next request reserves a slot. Uses the registered
                        // count, so a pop in this same cycle frees credit only
                        // from the next cycle on.
                        state_d = (fifo_count < CNT_W'(DEPTH - 1)) ? ST_REQ : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fifo_count < CNT_W'(DEPTH)) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Stale line is dropped; fetch resumes at the redirect PC.
                    if (line_ret) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Slots ahead of the entry point of the first line are not executed.
    always_comb begin
        push_entry.line = i_rinst;
        push_entry.pc   = line_align(fetch_pc_q, LINE_B);
        push_entry.mask = first_q ? ({FETCH_W{1'b1}} << fetch_pc_q[OFF_W-1:2])
                                  : {FETCH_W{1'b1}};
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_pc_valid   = (state_q != ST_HOLD) && !i_reset;
        o_pc         = line_align((state_q == ST_DRAIN) ? drain_pc_q : fetch_pc_q, LINE_B);
        o_inst_valid = !fifo_empty;
        o_inst       = fifo_empty ? '0 : head_entry.line;
        o_inst_pc    = fifo_empty ? '0 : head_entry.pc;
        o_inst_mask  = fifo_empty ? '0 : head_entry.mask;
        // A pop coinciding with a redirect is meaningless: the queue is flushed.
        fifo_pop     = !fifo_empty && i_dec_ready && !i_redirect;
    end

    inst_fetch_queue_fifo #(
        .WIDTH ($bits(q_entry_t)),
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_redirect),
        .i_push_vld (fifo_push),
        .i_push_dat (push_entry),
        .i_pop_rdy  (fifo_pop),
        .o_head_dat (head_entry),
        .o_empty    (fifo_empty),
        .o_count    (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a scoreboard of expected lines.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inst_fetch_queue;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_redirect;
    logic [31:0]  i_redirect_pc;
    logic         i_inst_ready;
    logic [127:0] i_rinst;
    logic         i_dec_ready;

    logic         o_pc_valid;
    logic [31:0]  o_pc;
    logic         o_inst_valid;
    logic [127:0] o_inst;
    logic [31:0]  o_inst_pc;
    logic [3:0]   o_inst_mask;

    // Second instance only differs in its reset PC (line-wrap check).
    logic         w_pc_valid;
    logic [31:0]  w_pc;
    logic         w_inst_valid;
    logic [127:0] w_inst;
    logic [31:0]  w_inst_pc;
    logic [3:0]   w_inst_mask;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  mask;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.FETCH_W(4), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_pc_valid(o_pc_valid), .o_pc(o_pc), .i_inst_ready(i_inst_ready), .i_rinst(i_rinst),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .o_inst_mask(o_inst_mask), .i_dec_ready(i_dec_ready)
    );

    inst_fetch_queue #(.FETCH_W(4), .DEPTH(4), .RESET_PC(32'hFFFF_FFF0)) dut_wrap (
        .i_clk(clk), .i_reset(i_reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_pc_valid(w_pc_valid), .o_pc(w_pc), .i_inst_ready(i_inst_ready), .i_rinst(i_rinst),
        .o_inst_valid(w_inst_valid), .o_inst(w_inst), .o_inst_pc(w_inst_pc),
        .o_inst_mask(w_inst_mask), .i_dec_ready(i_dec_ready)
    );

    // instMEM contents: each word encodes its own address.
    function automatic logic [127:0] line_of(input logic [31:0] pc);
        logic [31:0] b;
        b = pc & 32'hFFFF_FFF0;
        return {(b + 32'd12) ^ 32'hA5A5_0000, (b + 32'd8) ^ 32'hA5A5_0000,
                (b + 32'd4) ^ 32'hA5A5_0000, b ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_inst_ready  = 1'b0;
        i_rinst       = '0;
        i_dec_ready   = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("rst pc_valid", o_pc_valid, 1'b0);
        check("rst pc", o_pc, 32'h0);
        check("rst inst_valid", o_inst_valid, 1'b0);
        check("rst mask", o_inst_mask, 4'h0);
        check("rst wrap pc", w_pc, 32'hFFFF_FFF0);
        i_reset = 1'b0;
    endtask

    // Wait (bounded) for a line request and check its address.
    task automatic wait_req(input string tag, input logic [31:0] exp_pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_pc_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_vld"}, o_pc_valid, 1'b1);
        check({tag, " req_pc"}, o_pc, exp_pc);
    endtask

    // Compare the head line against the scoreboard (consumes the entry).
    task automatic check_head(input string tag);
        exp_t e;
        check({tag, " head_vld"}, o_inst_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " head_pc"}, o_inst_pc, e.pc);
            check({tag, " head_mask"}, o_inst_mask, e.mask);
            check({tag, " head_line"}, o_inst, line_of(e.pc));
        end
    endtask

    task automatic pop_check(input string tag);
        check_head(tag);
        i_dec_ready = 1'b1;
        @(negedge clk);
        i_dec_ready = 1'b0;
    endtask

    // Answer the outstanding request lat cycles after it was observed.
    task automatic serve(input int lat, input logic [3:0] mask, input bit pop_too);
        logic [31:0] pc;
        pc = o_pc;
        repeat (lat) @(negedge clk);
        check($sformatf("serve %0h stable", pc), {o_pc_valid, o_pc}, {1'b1, pc});
        if (pop_too) begin
            check_head($sformatf("serve %0h pop", pc));
            i_dec_ready = 1'b1;
        end
        i_inst_ready = 1'b1;
        i_rinst      = line_of(pc);
        sb.push_back('{pc: pc, mask: mask});
        @(negedge clk);
        i_inst_ready = 1'b0;
        i_dec_ready  = 1'b0;
        i_rinst      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- In-order fetch, 1-cycle latency, wrap instance ----
        do_reset();
        wait_req("t1 l0", 32'h0);
        check("t1 wrap first pc", w_pc, 32'hFFFF_FFF0);
        serve(1, 4'hF, 1'b0);
        check("t1 wrap second pc", w_pc, 32'h0000_0000);
        check("t1 wrap head pc", w_inst_pc, 32'hFFFF_FFF0);
        pop_check("t1 l0");
        for (int i = 1; i < 3; i++) begin
            wait_req($sformatf("t1 l%0d", i), 32'(i * 16));
            serve(1, 4'hF, 1'b0);
            pop_check($sformatf("t1 l%0d", i));
        end

        // ---- Fill the queue, HOLD, credit return, push+pop together ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("t2 l%0d", i), 32'(i * 16));
            serve(1, 4'hF, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2 hold %0d", i), o_pc_valid, 1'b0);
            @(negedge clk);
        end
        pop_check("t2 pop0");
        check("t2 credit next cycle", o_pc_valid, 1'b0);
        wait_req("t2 after pop", 32'h40);
        serve(2, 4'hF, 1'b1);
        check("t2 hold after push+pop", o_pc_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pop_check($sformatf("t2 drain %0d", i));
        end
        check("t2 empty", o_inst_valid, 1'b0);

        // ---- Redirect while a 3-cycle request is outstanding ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_req($sformatf("t3 l%0d", i), 32'(i * 16));
            serve(1, 4'hF, 1'b0);
        end
        wait_req("t3 l3", 32'h30);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h108;
        sb.delete();
        @(negedge clk);
        i_redirect = 1'b0;
        check("t3 flushed", o_inst_valid, 1'b0);
        check("t3 drain vld", o_pc_valid, 1'b1);
        check("t3 drain pc", o_pc, 32'h30);
        @(negedge clk);
        i_inst_ready = 1'b1;
        i_rinst      = line_of(32'h30);
        @(negedge clk);
        i_inst_ready = 1'b0;
        i_rinst      = '0;
        check("t3 stale dropped", o_inst_valid, 1'b0);
        wait_req("t3 target", 32'h100);
        serve(3, 4'b1100, 1'b0);
        pop_check("t3 target");
        wait_req("t3 next", 32'h110);
        serve(1, 4'hF, 1'b0);
        pop_check("t3 next");

        // ---- Redirect coincident with return strobe and pop ----
        wait_req("t4 l0", 32'h120);
        serve(1, 4'hF, 1'b0);
        wait_req("t4 l1", 32'h130);
        check_head("t4 pre");
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h204;
        i_inst_ready  = 1'b1;
        i_rinst       = line_of(32'h130);
        i_dec_ready   = 1'b1;
        sb.delete();
        @(negedge clk);
        i_redirect   = 1'b0;
        i_inst_ready = 1'b0;
        i_dec_ready  = 1'b0;
        i_rinst      = '0;
        check("t4 flushed", o_inst_valid, 1'b0);
        check("t4 req vld", o_pc_valid, 1'b1);
        check("t4 req pc", o_pc, 32'h200);
        serve(1, 4'b1110, 1'b0);
        pop_check("t4 target");
        check("t4 no stale", o_inst_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
